// File: rtl/pll_drp_pkg.sv
// Shared types, DRP address map and encoding constants for the PLL
// dynamic-reconfiguration sequencer.
package pll_drp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_ON,
    S_RD1,
    S_WR1,
    S_RD2,
    S_WR2,
    S_RST_OFF,
    S_WAIT_LOCK
  } state_e;

  localparam logic [2:0]  CH_FB          = 3'd7;
  localparam logic [6:0]  DIV_MAX        = 7'd64;
  localparam logic [15:0] REG1_KEEP_MASK = 16'hF000;
  localparam logic [15:0] REG2_KEEP_MASK = 16'hFF3F;

  typedef struct packed {
    logic [6:0] reg1;
    logic [6:0] reg2;
  } drp_addr_t;

  function automatic drp_addr_t ch_addr(input logic [2:0] ch);
    drp_addr_t a;
    case (ch)
      3'd0:    a = '{reg1: 7'h08, reg2: 7'h09};
      3'd1:    a = '{reg1: 7'h0A, reg2: 7'h0B};
      3'd2:    a = '{reg1: 7'h0C, reg2: 7'h0D};
      3'd3:    a = '{reg1: 7'h0E, reg2: 7'h0F};
      3'd4:    a = '{reg1: 7'h10, reg2: 7'h11};
      3'd5:    a = '{reg1: 7'h06, reg2: 7'h07};
      3'd7:    a = '{reg1: 7'h14, reg2: 7'h15};
      default: a = '{reg1: 7'h00, reg2: 7'h00};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/pll_drp_div_enc.sv
// Combinational divide-value to PLL counter-field encoder
// (high/low times, edge and no-count bits).
module pll_drp_div_enc (
  input  logic [6:0] div,
  output logic [5:0] high_time,
  output logic [5:0] low_time,
  output logic       edge_en,
  output logic       no_count
);

  always_comb begin
    no_count  = (div == 7'd1);
    high_time = div[6:1];
    // 6-bit difference is exact: D - floor(D/2) never exceeds 32 for D <= 64
    low_time  = div[5:0] - div[6:1];
    edge_en   = div[0];
    // divide-by-1 bypasses the counter; fields are 1/1 and edge stays low
    if (no_count) begin
      high_time = 6'd1;
      low_time  = 6'd1;
      edge_en   = 1'b0;
    end
  end

endmodule

// File: rtl/pll_drp_seq.sv
// Reprograms one PLL output divider over DRP: read-modify-write of ClkReg1
// and ClkReg2 with the PLL held in reset, then waits for LOCKED.
module pll_drp_seq
  import pll_drp_pkg::*;
#(
  parameter int unsigned NUM_CH       = 6,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_CH,
  input  logic [6:0]  REQ_DIVIDE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED
);

  localparam int unsigned DTW = $clog2(DRDY_TIMEOUT + 1);
  localparam int unsigned LTW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [DTW-1:0] DRDY_LAST = DTW'(DRDY_TIMEOUT - 1);
  localparam logic [LTW-1:0] LOCK_LAST = LTW'(LOCK_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [2:0]     ch_q, ch_d;
  logic [6:0]     div_q, div_d;
  logic [6:0]     daddr_q, daddr_d;
  logic           den_q, den_d;
  logic           dwe_q, dwe_d;
  logic [15:0]    di_q, di_d;
  logic           pll_rst_q, pll_rst_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           abort_q, abort_d;
  logic [DTW-1:0] drdy_tmr_q, drdy_tmr_d;
  logic [LTW-1:0] lock_tmr_q, lock_tmr_d;

  logic [5:0]     high_time, low_time;
  logic           edge_en, no_count;
  logic           req_bad;
  logic           drdy_hit;
  drp_addr_t      addr;

  pll_drp_div_enc u_div_enc (
    .div       (div_q),
    .high_time (high_time),
    .low_time  (low_time),
    .edge_en   (edge_en),
    .no_count  (no_count)
  );

  assign addr     = ch_addr(ch_q);
  assign req_bad  = (REQ_DIVIDE == 7'd0) || (REQ_DIVIDE > DIV_MAX) ||
                    ((REQ_CH != CH_FB) && (32'(REQ_CH) >= NUM_CH));
  // DRDY only counts once the DEN pulse has been presented to the PLL
  assign drdy_hit = DRDY && !den_q;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    div_d      = div_q;
    daddr_d    = daddr_q;
    den_d      = 1'b0;
    dwe_d      = dwe_q;
    di_d       = di_q;
    pll_rst_d  = pll_rst_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    abort_d    = abort_q;
    drdy_tmr_d = '0;
    lock_tmr_d = '0;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d   = S_RST_ON;
            pll_rst_d = 1'b1;
            ch_d      = REQ_CH;
            div_d     = REQ_DIVIDE;
          end
        end
      end

      S_RST_ON: begin
        state_d = S_RD1;
        den_d   = 1'b1;
        dwe_d   = 1'b0;
        daddr_d = addr.reg1;
        di_d    = '0;
      end

      S_RD1, S_WR1, S_RD2, S_WR2: begin
        if (drdy_hit) begin
          case (state_q)
            S_RD1: begin
              state_d = S_WR1;
              den_d   = 1'b1;
              dwe_d   = 1'b1;
              di_d    = (DO & REG1_KEEP_MASK) | {4'b0, high_time, low_time};
            end
            S_WR1: begin
              state_d = S_RD2;
              den_d   = 1'b1;
              dwe_d   = 1'b0;
              daddr_d = addr.reg2;
              di_d    = '0;
            end
            S_RD2: begin
              state_d = S_WR2;
              den_d   = 1'b1;
              dwe_d   = 1'b1;
              di_d    = (DO & REG2_KEEP_MASK) | {8'b0, edge_en, no_count, 6'b0};
            end
            default: begin
              state_d   = S_RST_OFF;
              dwe_d     = 1'b0;
              pll_rst_d = 1'b0;
            end
          endcase
        end else if (drdy_tmr_q == DRDY_LAST) begin
          // timeout detours through RST_OFF so PLL_RST falls after the ERR cycle
          state_d = S_RST_OFF;
          err_d   = 1'b1;
          abort_d = 1'b1;
          dwe_d   = 1'b0;
        end else begin
          drdy_tmr_d = drdy_tmr_q + 1'b1;
        end
      end

      S_RST_OFF: begin
        pll_rst_d = 1'b0;
        if (abort_q) begin
          state_d = S_IDLE;
          abort_d = 1'b0;
        end else begin
          state_d    = S_WAIT_LOCK;
          lock_tmr_d = lock_tmr_q + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        if (LOCKED) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (lock_tmr_q == LOCK_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          lock_tmr_d = lock_tmr_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      div_q      <= '0;
      daddr_q    <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      di_q       <= '0;
      pll_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      drdy_tmr_q <= '0;
      lock_tmr_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      div_q      <= div_d;
      daddr_q    <= daddr_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      di_q       <= di_d;
      pll_rst_q  <= pll_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      drdy_tmr_q <= drdy_tmr_d;
      lock_tmr_q <= lock_tmr_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign DADDR     = daddr_q;
  assign DEN       = den_q;
  assign DWE       = dwe_q;
  assign DI        = di_q;
  assign PLL_RST   = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_seq.sv
// Bench for pll_drp_seq: table vectors, randomized requests against an
// arithmetic reference model, and hand-built abort/timeout sequences.
module tb_pll_drp_seq;

  localparam int unsigned NUM_CH  = 6;
  localparam int unsigned DRDY_TO = 64;
  localparam int unsigned LOCK_TO = 1024;

  logic        DCLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [2:0]  REQ_CH = '0;
  logic [6:0]  REQ_DIVIDE = '0;
  logic        BUSY, DONE, ERR;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b0;
  logic        PLL_RST;
  logic        LOCKED = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  ch;
    logic [6:0]  d;
    logic [15:0] do1;
    logic [15:0] do2;
    int          lat;
    int          lock;
    bit          rej;
    logic [6:0]  a1;
    logic [6:0]  a2;
    logic [15:0] w1;
    logic [15:0] w2;
  } vec_t;

  always #5 DCLK = ~DCLK;

  pll_drp_seq #(
    .NUM_CH       (NUM_CH),
    .DRDY_TIMEOUT (DRDY_TO),
    .LOCK_TIMEOUT (LOCK_TO)
  ) dut (
    .DCLK       (DCLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_CH     (REQ_CH),
    .REQ_DIVIDE (REQ_DIVIDE),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR),
    .DADDR      (DADDR),
    .DEN        (DEN),
    .DWE        (DWE),
    .DI         (DI),
    .DO         (DO),
    .DRDY       (DRDY),
    .PLL_RST    (PLL_RST),
    .LOCKED     (LOCKED)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: divide encoding straight from the field rules.
  function automatic vec_t model(input int ch, input int d, input logic [15:0] do1,
                                 input logic [15:0] do2, input int lat, input int lock);
    vec_t v;
    int base [8];
    int hi, lo, edg, nc;
    base = '{8, 10, 12, 14, 16, 6, 0, 20};
    v.ch = 3'(ch); v.d = 7'(d); v.do1 = do1; v.do2 = do2; v.lat = lat; v.lock = lock;
    v.rej = (d < 1) || (d > 64) || (ch != 7 && ch >= int'(NUM_CH));
    if (d == 1) begin
      hi = 1; lo = 1; edg = 0; nc = 1;
    end else begin
      hi = d / 2; lo = d - hi; edg = d % 2; nc = 0;
    end
    v.a1 = 7'(base[ch]);
    v.a2 = 7'(base[ch] + 1);
    v.w1 = 16'((int'(do1) / 4096) * 4096 + hi * 64 + lo);
    v.w2 = 16'((int'(do2) / 256) * 256 + edg * 128 + nc * 64 + int'(do2) % 64);
    return v;
  endfunction

  task automatic wait_den(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (DEN === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge DCLK);
    end
  endtask

  // Entered and left at a negedge. stop_at < 4 returns at the negedge that
  // shows the DEN of access number stop_at, leaving it unanswered.
  task automatic run_seq(input string tag, input vec_t v, input int stop_at);
    logic [6:0]  ea [4];
    logic [15:0] ew [4];
    logic [15:0] rd [4];
    bit ok;
    ea = '{v.a1, v.a1, v.a2, v.a2};
    ew = '{16'h0, v.w1, 16'h0, v.w2};
    rd = '{v.do1, 16'h0, v.do2, 16'h0};
    chk({tag, "_ready"}, REQ_READY, 1);
    REQ_VALID  = 1'b1;
    REQ_CH     = v.ch;
    REQ_DIVIDE = v.d;
    @(negedge DCLK);
    REQ_VALID  = 1'b0;
    REQ_CH     = 3'($urandom);
    REQ_DIVIDE = 7'($urandom);
    if (v.rej) begin
      chk({tag, "_rej_err"}, ERR, 1);
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_rej_den"}, DEN, 0);
        chk({tag, "_rej_pllrst"}, PLL_RST, 0);
        if (i == 1) chk({tag, "_rej_err_pulse"}, ERR, 0);
        @(negedge DCLK);
      end
      return;
    end
    chk({tag, "_pllrst_on"}, PLL_RST, 1);
    chk({tag, "_no_err"}, ERR, 0);
    for (int k = 0; k < 4; k++) begin
      wait_den(ok);
      chk({tag, "_den_seen"}, ok, 1);
      if (!ok) return;
      chk({tag, "_daddr"}, DADDR, ea[k]);
      chk({tag, "_dwe"}, DWE, (k % 2));
      if (k % 2 == 1) chk({tag, "_di"}, DI, ew[k]);
      chk({tag, "_pllrst_held"}, PLL_RST, 1);
      if (k == stop_at) return;
      for (int i = 0; i < v.lat; i++) begin
        @(negedge DCLK);
        chk({tag, "_den_width"}, DEN, 0);
        chk({tag, "_daddr_stable"}, DADDR, ea[k]);
        chk({tag, "_dwe_stable"}, DWE, (k % 2));
        if (k % 2 == 1) chk({tag, "_di_stable"}, DI, ew[k]);
      end
      DRDY = 1'b1;
      DO   = rd[k];
      @(negedge DCLK);
      DRDY = 1'b0;
      DO   = 16'($urandom);
    end
    chk({tag, "_pllrst_off"}, PLL_RST, 0);
    if (v.lock < 0) begin
      int n = 0;
      while (ERR !== 1'b1 && n < int'(LOCK_TO) + 50) begin
        @(negedge DCLK);
        n++;
      end
      chk({tag, "_lock_timeout_cycles"}, n, LOCK_TO);
      chk({tag, "_lock_timeout_nodone"}, DONE, 0);
      chk({tag, "_lock_timeout_ready"}, REQ_READY, 1);
      @(negedge DCLK);
      chk({tag, "_lock_timeout_pulse"}, ERR, 0);
      return;
    end
    for (int i = 0; i < v.lock; i++) begin
      chk({tag, "_no_early_done"}, DONE, 0);
      @(negedge DCLK);
    end
    LOCKED = 1'b1;
    @(negedge DCLK);
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_done_ready"}, REQ_READY, 1);
    LOCKED = 1'b0;
    @(negedge DCLK);
    chk({tag, "_done_pulse"}, DONE, 0);
  endtask

  logic prev_den = 1'b0;
  always @(negedge DCLK) begin
    if (RST !== 1'b0) begin
      prev_den <= 1'b0;
    end else begin
      chk("busy_vs_ready", BUSY, !REQ_READY);
      chk("done_err_excl", DONE & ERR, 0);
      chk("den_single", prev_den & DEN, 0);
      prev_den <= DEN;
    end
  end

  vec_t tbl [8];
  vec_t v;

  initial begin
    tbl[0] = '{3'd0, 7'd5,  16'hF000, 16'h1234, 1, 10, 1'b0, 7'h08, 7'h09, 16'hF083, 16'h12B4};
    tbl[1] = '{3'd5, 7'd1,  16'h0000, 16'h0000, 1, 3,  1'b0, 7'h06, 7'h07, 16'h0041, 16'h0040};
    tbl[2] = '{3'd7, 7'd64, 16'h0000, 16'h0000, 2, 1,  1'b0, 7'h14, 7'h15, 16'h0820, 16'h0000};
    tbl[3] = '{3'd2, 7'd0,  16'h0000, 16'h0000, 1, 1,  1'b1, 7'h00, 7'h00, 16'h0000, 16'h0000};
    tbl[4] = '{3'd6, 7'd5,  16'h0000, 16'h0000, 1, 1,  1'b1, 7'h00, 7'h00, 16'h0000, 16'h0000};
    tbl[5] = '{3'd3, 7'd65, 16'h0000, 16'h0000, 1, 1,  1'b1, 7'h00, 7'h00, 16'h0000, 16'h0000};
    tbl[6] = '{3'd1, 7'd2,  16'hFFFF, 16'hFFFF, 3, 5,  1'b0, 7'h0A, 7'h0B, 16'hF041, 16'hFF3F};
    tbl[7] = '{3'd4, 7'd63, 16'h0ABC, 16'h5A5A, 1, 2,  1'b0, 7'h10, 7'h11, 16'h07E0, 16'h5A9A};

    // reset wins over a pending request and stray DRDY/LOCKED
    RST = 1'b1; REQ_VALID = 1'b1; REQ_CH = 3'd0; REQ_DIVIDE = 7'd5; DRDY = 1'b1; LOCKED = 1'b1;
    repeat (3) @(negedge DCLK);
    chk("rst_ready", REQ_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_den", DEN, 0);
    chk("rst_dwe", DWE, 0);
    chk("rst_pllrst", PLL_RST, 0);
    chk("rst_daddr", DADDR, 0);
    chk("rst_di", DI, 0);
    RST = 1'b0; REQ_VALID = 1'b0; DRDY = 1'b0; LOCKED = 1'b0;
    @(negedge DCLK);

    DRDY = 1'b1;
    @(negedge DCLK);
    DRDY = 1'b0;
    chk("idle_drdy_den", DEN, 0);
    chk("idle_drdy_busy", BUSY, 0);
    chk("idle_drdy_err", ERR, 0);

    for (int i = 0; i < 8; i++) run_seq($sformatf("vec%0d", i), tbl[i], 4);

    for (int i = 0; i < 40; i++) begin
      v = model($urandom_range(0, 7), $urandom_range(0, 70), 16'($urandom), 16'($urandom),
                $urandom_range(1, 4), $urandom_range(1, 12));
      run_seq($sformatf("rnd%0d", i), v, 4);
    end

    // WR1 never answered
    begin
      int n = 0;
      run_seq("drdy_to", tbl[0], 1);
      while (ERR !== 1'b1 && n < 200) begin
        @(negedge DCLK);
        n++;
      end
      chk("drdy_to_cycles", n, DRDY_TO);
      chk("drdy_to_nodone", DONE, 0);
      @(negedge DCLK);
      chk("drdy_to_pllrst", PLL_RST, 0);
      chk("drdy_to_ready", REQ_READY, 1);
      chk("drdy_to_err_pulse", ERR, 0);
      DRDY = 1'b1;
      @(negedge DCLK);
      DRDY = 1'b0;
      chk("late_drdy_den", DEN, 0);
      chk("late_drdy_busy", BUSY, 0);
    end

    // reset while RD2 is outstanding
    run_seq("rst_rd2", tbl[0], 2);
    RST = 1'b1;
    @(negedge DCLK);
    RST = 1'b0;
    chk("rst_rd2_ready", REQ_READY, 1);
    chk("rst_rd2_pllrst", PLL_RST, 0);
    chk("rst_rd2_den", DEN, 0);
    chk("rst_rd2_done", DONE, 0);
    chk("rst_rd2_err", ERR, 0);
    DRDY = 1'b1;
    DO   = 16'h1234;
    @(negedge DCLK);
    DRDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rd2_quiet_den", DEN, 0);
      chk("rst_rd2_quiet_done", DONE, 0);
      chk("rst_rd2_quiet_err", ERR, 0);
      @(negedge DCLK);
    end
    run_seq("after_rst", tbl[0], 4);

    // LOCKED never rises
    v = tbl[6];
    v.lock = -1;
    run_seq("lock_to", v, 4);

    run_seq("final", tbl[7], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_drp_seq.md
PLL_DRP_SEQ -- requirements
Module: pll_drp_seq

Interface
REQ-001 Parameter NUM_CH, default 6, number of reprogrammable CLKOUTn channels (1..6); channel index 7 selects CLKFBOUT.
REQ-002 Parameter DRDY_TIMEOUT, default 64, maximum DCLK cycles from a DEN pulse to DRDY.
REQ-003 Parameter LOCK_TIMEOUT, default 1024, maximum DCLK cycles from PLL reset release to LOCKED.
REQ-004 DCLK  input  1  sole clock; every flop is clocked on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 REQ_VALID  input  1  a reprogram request is present.
REQ-007 REQ_READY  output  1  the block accepts a request this cycle.
REQ-008 REQ_CH  input  3  target channel: 0..NUM_CH-1 selects CLKOUTn; 7 selects CLKFBOUT.
REQ-009 REQ_DIVIDE  input  7  new divide value for the channel; legal range 1..64.
REQ-010 BUSY  output  1  a sequence is in progress.
REQ-011 DONE  output  1  one-cycle pulse when a sequence completes successfully.
REQ-012 ERR  output  1  one-cycle pulse when a sequence is rejected or aborted.
REQ-013 DADDR / DEN / DWE / DI  output  7/1/1/16  DRP master outputs to the PLL.
REQ-014 DO / DRDY  input  16/1  DRP read data and completion strobe from the PLL.
REQ-015 PLL_RST  output  1  drives the PLL RST input.
REQ-016 LOCKED  input  1  the PLL LOCKED output.

Function
REQ-017 A request SHALL be accepted only when REQ_VALID and REQ_READY are both high; REQ_READY SHALL be high only in IDLE.
REQ-018 An accepted request with REQ_DIVIDE of 0 or greater than 64, or with an unmapped REQ_CH (NUM_CH..6), SHALL pulse ERR one cycle later and SHALL NOT generate any DRP traffic or PLL_RST.
REQ-019 The FSM SHALL step through the states IDLE, RST_ON, RD1, WR1, RD2, WR2, RST_OFF, WAIT_LOCK and back to IDLE.
REQ-020 PLL_RST SHALL go high the cycle after acceptance and SHALL stay high until the cycle after the WR2 DRDY.
REQ-021 Each DRP access SHALL be a DEN pulse exactly one cycle wide, with DADDR, DWE and DI held stable until DRDY.
REQ-022 DRDY SHALL be ignored when no access is outstanding.
REQ-023 Reg1 (ClkReg1) write data SHALL be {read[15:12], high[5:0], low[5:0]}.
REQ-024 Reg2 (ClkReg2) write data SHALL be {read[15:8], edge, no_count, read[5:0]}.
REQ-025 The divide encoding SHALL be:
- high = floor(D/2) and low = D - high;
- edge = D[0];
- no_count = (D == 1), and for D == 1 both high and low SHALL be 1;
- a 6-bit field value of 32 SHALL be written as-is (fields never wrap).
REQ-026 Each of RD1, WR1, RD2 and WR2 SHALL wait for DRDY.
REQ-027 If DRDY is missing after DRDY_TIMEOUT cycles, the block SHALL:
- pulse ERR;
- drop PLL_RST the next cycle;
- return to IDLE.
REQ-028 WAIT_LOCK SHALL pulse DONE on the first cycle LOCKED is sampled high; it SHALL pulse ERR if LOCKED stays low for LOCK_TIMEOUT cycles.
REQ-029 DONE and ERR SHALL never be high in the same cycle.
REQ-030 BUSY SHALL equal !REQ_READY.

Reset
REQ-031 RST SHALL take priority over every other input.
REQ-032 On RST:
- the FSM SHALL go to IDLE and both timers SHALL clear;
- REQ_READY SHALL be 1;
- BUSY, DONE, ERR, DEN, DWE and PLL_RST SHALL be 0;
- DADDR and DI SHALL be 0.
REQ-033 RST asserted mid-sequence SHALL abort without completing the pending DRP access, deassert PLL_RST, and pulse neither DONE nor ERR.

Structure
REQ-034 Package pll_drp_pkg SHALL hold:
- the FSM state enum;
- the Reg1/Reg2 address table: CLKOUT0 08/09, CLKOUT1 0A/0B, CLKOUT2 0C/0D, CLKOUT3 0E/0F, CLKOUT4 10/11, CLKOUT5 06/07, CLKFBOUT 14/15;
- the field masks;
- the divide limit 64.
REQ-035 The divide encoding SHALL live in the combinational sub-module pll_drp_div_enc (D in; high, low, edge, no_count out).

Verification
REQ-036 Ch0, D=5, DO reads 0xF000 then 0x1234 (1-cycle DRDY) -> writes 0xF083 to 0x08 and 0x12B4 to 0x09; LOCKED asserted 10 cycles after PLL_RST falls -> DONE pulses.
REQ-037 Ch5, D=1, DO reads 0x0000 twice -> writes 0x0041 to 0x06 and 0x0040 to 0x07.
REQ-038 Ch7, D=64 -> writes 0x0820 to 0x14 and 0x0000 edge/no_count to 0x15.
REQ-039 D=0, and separately ch6 with NUM_CH=6 -> ERR one cycle after acceptance; DEN and PLL_RST stay 0.
REQ-040 DRDY withheld on WR1 -> ERR 64 cycles after DEN, PLL_RST low the next cycle, REQ_READY back to 1.
REQ-041 RST pulsed during RD2 -> next cycle IDLE, PLL_RST=0, no DONE/ERR; a new request is then accepted normally.
